// File: rtl/color_scan_classifier_if.sv
// ----------------------------------------------------------------------------
// color_scan_classifier_if
// Bundles the sensor pins, control inputs and result outputs of
// color_scan_classifier.
//   master : host side (drives en/scale/sel/min_thresh/sensor_out)
//   slave  : classifier side (drives s0..s3, counts, frame/class results)
// Parameter CNT_W must match the classifier's CNT_W.
// ----------------------------------------------------------------------------
interface color_scan_classifier_if #(
    parameter int unsigned CNT_W = 24
) ();
    logic             en;
    logic [1:0]       scale;
    logic [2:0]       sel;
    logic [CNT_W-1:0] min_thresh;
    logic             sensor_out;
    logic             s0;
    logic             s1;
    logic             s2;
    logic             s3;
    logic [CNT_W-1:0] red_count;
    logic [CNT_W-1:0] green_count;
    logic [CNT_W-1:0] blue_count;
    logic [CNT_W-1:0] clear_count;
    logic             frame_valid;
    logic [1:0]       class_code;
    logic             class_changed;
    logic             match;

    modport master (
        output en, scale, sel, min_thresh, sensor_out,
        input  s0, s1, s2, s3,
        input  red_count, green_count, blue_count, clear_count,
        input  frame_valid, class_code, class_changed, match
    );

    modport slave (
        input  en, scale, sel, min_thresh, sensor_out,
        output s0, s1, s2, s3,
        output red_count, green_count, blue_count, clear_count,
        output frame_valid, class_code, class_changed, match
    );
endinterface

// File: rtl/color_scan_classifier.sv
// ----------------------------------------------------------------------------
// color_scan_classifier
// Sequences a TCS3200 colour sensor through its photodiode filters, counts
// OUT rising edges per channel window, and classifies each frame as
// red / green / blue / none with a consecutive-frame debounce.
//
// Ports:
//   clk       : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   bus       : color_scan_classifier_if.slave
//               in : en, scale[1:0], sel[2:0], min_thresh, sensor_out
//               out: s0..s3, red/green/blue/clear_count, frame_valid,
//                    class_code[1:0], class_changed, match
//
// Build option: define COLOR_CLEAR_CHANNEL_EN to add the clear (unfiltered)
// channel as a fourth phase of every frame; otherwise clear_count stays 0.
// ----------------------------------------------------------------------------
module color_scan_classifier #(
    parameter int unsigned WINDOW_CYCLES = 5_000_000,
    parameter int unsigned SETTLE_CYCLES = 10_000,
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned CONFIRM_N     = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    color_scan_classifier_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_COUNT  = 2'd2;

    localparam logic [1:0] CH_RED   = 2'd0;
    localparam logic [1:0] CH_GREEN = 2'd1;
    localparam logic [1:0] CH_BLUE  = 2'd2;
`ifdef COLOR_CLEAR_CHANNEL_EN
    localparam logic [1:0] LAST_CH  = 2'd3;
`else
    localparam logic [1:0] LAST_CH  = 2'd2;
`endif

    localparam int unsigned TIMER_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
    localparam int unsigned CONF_W    = $clog2(CONFIRM_N + 1);

    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WINDOW_LAST = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [CONF_W-1:0]  CONF_MAX    = CONF_W'(CONFIRM_N);

    // {s2,s3} filter select for a channel index; index 3 is the clear channel
    function automatic logic [1:0] filter_code(input logic [1:0] ch);
        case (ch)
            CH_RED:   filter_code = 2'b00;
            CH_GREEN: filter_code = 2'b11;
            CH_BLUE:  filter_code = 2'b01;
            default:  filter_code = 2'b10;
        endcase
    endfunction

    logic [1:0]         state_q,    state_d;
    logic [TIMER_W-1:0] timer_q,    timer_d;
    logic [1:0]         ch_q,       ch_d;
    logic [1:0]         filt_q,     filt_d;
    logic [CNT_W-1:0]   pulse_q,    pulse_d;
    logic [CNT_W-1:0]   red_q,      red_d;
    logic [CNT_W-1:0]   green_q,    green_d;
    logic [CNT_W-1:0]   blue_q,     blue_d;
    logic [CNT_W-1:0]   clear_q,    clear_d;
    logic               fv_q,       fv_d;
    logic [1:0]         class_q,    class_d;
    logic               chg_q,      chg_d;
    logic [CONF_W-1:0]  conf_q,     conf_d;
    logic [1:0]         last_raw_q, last_raw_d;
    logic               sync_q1,    sync_q2;

    logic               edge_c;
    logic [CNT_W-1:0]   pulse_next_c;
    logic [1:0]         next_ch_c;
    logic [1:0]         raw_c;
    logic               match_c;

    // sensor_out is asynchronous; one count per synchronized rising edge
    assign edge_c = sync_q1 & ~sync_q2;

    // Saturating increment so a bright target never wraps to a small count
    assign pulse_next_c = (edge_c && (pulse_q != '1)) ? pulse_q + CNT_W'(1) : pulse_q;

    assign next_ch_c = (ch_q == LAST_CH) ? CH_RED : ch_q + 2'd1;

    // Raw frame class: strictly largest of R/G/B and above threshold
    always_comb begin
        raw_c = 2'd0;
        if ((red_q > green_q) && (red_q > blue_q) && (red_q > bus.min_thresh))
            raw_c = 2'd1;
        else if ((green_q > red_q) && (green_q > blue_q) && (green_q > bus.min_thresh))
            raw_c = 2'd2;
        else if ((blue_q > red_q) && (blue_q > green_q) && (blue_q > bus.min_thresh))
            raw_c = 2'd3;
    end

    // Next-state: channel sequencing, window counting, debounce
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        ch_d       = ch_q;
        filt_d     = filt_q;
        pulse_d    = pulse_q;
        red_d      = red_q;
        green_d    = green_q;
        blue_d     = blue_q;
        clear_d    = clear_q;
        fv_d       = 1'b0;
        class_d    = class_q;
        chg_d      = 1'b0;
        conf_d     = conf_q;
        last_raw_d = last_raw_q;

        if (!bus.en) begin
            // Abort any window; stored counts and class are left untouched
            state_d = ST_IDLE;
            timer_d = '0;
            ch_d    = CH_RED;
            filt_d  = filter_code(CH_RED);
            pulse_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SETTLE;
                    timer_d = '0;
                    ch_d    = CH_RED;
                    filt_d  = filter_code(CH_RED);
                    pulse_d = '0;
                end
                ST_SETTLE: begin
                    if (timer_q == SETTLE_LAST) begin
                        state_d = ST_COUNT;
                        timer_d = '0;
                        pulse_d = '0;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                ST_COUNT: begin
                    pulse_d = pulse_next_c;
                    if (timer_q == WINDOW_LAST) begin
                        // Store includes an edge seen in this final cycle
                        case (ch_q)
                            CH_RED:   red_d   = pulse_next_c;
                            CH_GREEN: green_d = pulse_next_c;
                            CH_BLUE:  blue_d  = pulse_next_c;
                            default: begin
`ifdef COLOR_CLEAR_CHANNEL_EN
                                clear_d = pulse_next_c;
`endif
                            end
                        endcase
                        pulse_d = '0;
                        timer_d = '0;
                        state_d = ST_SETTLE;
                        ch_d    = next_ch_c;
                        filt_d  = filter_code(next_ch_c);
                        fv_d    = (ch_q == LAST_CH);
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    ch_d    = CH_RED;
                    filt_d  = filter_code(CH_RED);
                    pulse_d = '0;
                end
            endcase
        end

        // Debounce: class evaluated while frame_valid is high
        if (fv_q) begin
            last_raw_d = raw_c;
            if ((raw_c == last_raw_q) && (conf_q != '0))
                conf_d = (conf_q >= CONF_MAX) ? conf_q : conf_q + CONF_W'(1);
            else
                conf_d = CONF_W'(1);
            if ((conf_d >= CONF_MAX) && (raw_c != class_q)) begin
                class_d = raw_c;
                chg_d   = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            ch_q       <= CH_RED;
            filt_q     <= 2'b00;
            pulse_q    <= '0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            clear_q    <= '0;
            fv_q       <= 1'b0;
            class_q    <= 2'd0;
            chg_q      <= 1'b0;
            conf_q     <= '0;
            last_raw_q <= 2'd0;
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ch_q       <= ch_d;
            filt_q     <= filt_d;
            pulse_q    <= pulse_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
            clear_q    <= clear_d;
            fv_q       <= fv_d;
            class_q    <= class_d;
            chg_q      <= chg_d;
            conf_q     <= conf_d;
            last_raw_q <= last_raw_d;
            sync_q1    <= bus.sensor_out;
            sync_q2    <= sync_q1;
        end
    end

    // Target match follows class_code and sel without a register stage
    always_comb begin
        match_c = 1'b0;
        case (class_q)
            2'd1:    match_c = bus.sel[0];
            2'd2:    match_c = bus.sel[1];
            2'd3:    match_c = bus.sel[2];
            default: match_c = 1'b0;
        endcase
    end

    assign bus.s0            = bus.scale[1];
    assign bus.s1            = bus.scale[0];
    assign bus.s2            = filt_q[1];
    assign bus.s3            = filt_q[0];
    assign bus.red_count     = red_q;
    assign bus.green_count   = green_q;
    assign bus.blue_count    = blue_q;
    assign bus.clear_count   = clear_q;
    assign bus.frame_valid   = fv_q;
    assign bus.class_code    = class_q;
    assign bus.class_changed = chg_q;
    assign bus.match         = match_c;

endmodule

// File: tb/tb_color_scan_classifier.sv
// ----------------------------------------------------------------------------
// tb_color_scan_classifier
// Directed bench for color_scan_classifier (clear channel not compiled in).
// Main instance: WINDOW=100, SETTLE=10, CNT_W=8, CONFIRM_N=2, min_thresh=5.
// A second instance with a 700-cycle window exercises count saturation.
// ----------------------------------------------------------------------------
module tb_color_scan_classifier;
    localparam int unsigned WIN  = 100;
    localparam int unsigned SWIN = 700;
    localparam int unsigned SET  = 10;
    localparam int unsigned CW   = 8;
    localparam int unsigned CONF = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sensor = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    color_scan_classifier_if #(.CNT_W(CW)) bus ();
    color_scan_classifier_if #(.CNT_W(CW)) sbus ();

    assign bus.sensor_out  = sensor;
    assign sbus.sensor_out = sensor;

    color_scan_classifier #(
        .WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET), .CNT_W(CW), .CONFIRM_N(CONF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    color_scan_classifier #(
        .WINDOW_CYCLES(SWIN), .SETTLE_CYCLES(SET), .CNT_W(CW), .CONFIRM_N(CONF)
    ) dut_sat (
        .clk(clk), .reset_n(reset_n), .bus(sbus.slave)
    );

    // One channel phase (settle + window). Pulses start off_abs cycles after
    // the settle begins, each high hp cycles then low hp cycles. lead = cycles
    // of this phase already consumed by the caller. Checks the filter code.
    task automatic run_channel(input bit sat, input int ch, input int n, input int off_abs,
                               input int hp, input int lead);
        int         win;
        int         used;
        logic [1:0] exp_f;
        logic [1:0] got_f;
        win   = sat ? int'(SWIN) : int'(WIN);
        exp_f = (ch == 0) ? 2'b00 : (ch == 1) ? 2'b11 : 2'b01;
        #1;
        got_f = sat ? {sbus.s2, sbus.s3} : {bus.s2, bus.s3};
        checks++; if (got_f !== exp_f) begin failures++; $display("FAIL filter_ch%0d got=%b exp=%b", ch, got_f, exp_f); end
        if (n == 0) begin
            repeat (int'(SET) + win - lead) @(posedge clk);
        end else begin
            repeat (off_abs - lead) @(posedge clk);
            for (int i = 0; i < n; i++) begin
                #1 sensor = 1'b1;
                repeat (hp) @(posedge clk);
                #1 sensor = 1'b0;
                if (i < n - 1) repeat (hp) @(posedge clk);
            end
            used = off_abs + 2 * hp * n - hp;
            repeat (int'(SET) + win - used) @(posedge clk);
        end
    endtask

    task automatic run_frame(input int r, input int g, input int b, input int lead);
        run_channel(1'b0, 0, r, 15, 2, lead);
        run_channel(1'b0, 1, g, 15, 2, 0);
        run_channel(1'b0, 2, b, 15, 2, 0);
    endtask

    task automatic start_scan();
        #1 bus.en = 1'b1;
        @(posedge clk);
    endtask

    task automatic stop_scan();
        #1 bus.en = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({bus.s2, bus.s3} !== 2'b00) begin failures++; $display("FAIL rst_filter got=%b exp=00", {bus.s2, bus.s3}); end
        checks++; if ({bus.s0, bus.s1} !== 2'b10) begin failures++; $display("FAIL rst_scale got=%b exp=10", {bus.s0, bus.s1}); end
        checks++; if (bus.red_count !== 8'd0 || bus.green_count !== 8'd0 || bus.blue_count !== 8'd0 || bus.clear_count !== 8'd0) begin failures++; $display("FAIL rst_counts got=%0d/%0d/%0d/%0d exp=0/0/0/0", bus.red_count, bus.green_count, bus.blue_count, bus.clear_count); end
        checks++; if (bus.frame_valid !== 1'b0 || bus.class_changed !== 1'b0) begin failures++; $display("FAIL rst_pulses got=%b%b exp=00", bus.frame_valid, bus.class_changed); end
        checks++; if (bus.class_code !== 2'd0 || bus.match !== 1'b0) begin failures++; $display("FAIL rst_class got=%0d/%b exp=0/0", bus.class_code, bus.match); end
        #2 reset_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_dominant_red();
        start_scan();
        run_frame(20, 4, 4, 0);
        #1;
        checks++; if (bus.frame_valid !== 1'b1) begin failures++; $display("FAIL red_fv1 got=%b exp=1", bus.frame_valid); end
        checks++; if (bus.red_count !== 8'd20 || bus.green_count !== 8'd4 || bus.blue_count !== 8'd4) begin failures++; $display("FAIL red_counts1 got=%0d/%0d/%0d exp=20/4/4", bus.red_count, bus.green_count, bus.blue_count); end
        checks++; if (bus.clear_count !== 8'd0) begin failures++; $display("FAIL red_clear got=%0d exp=0", bus.clear_count); end
        @(posedge clk); #1;
        checks++; if (bus.class_code !== 2'd0 || bus.class_changed !== 1'b0) begin failures++; $display("FAIL red_unconfirmed got=%0d/%b exp=0/0", bus.class_code, bus.class_changed); end
        checks++; if (bus.frame_valid !== 1'b0) begin failures++; $display("FAIL red_fv_pulse got=%b exp=0", bus.frame_valid); end
        run_frame(20, 4, 4, 1);
        #1;
        checks++; if (bus.frame_valid !== 1'b1) begin failures++; $display("FAIL red_fv2 got=%b exp=1", bus.frame_valid); end
        @(posedge clk); #1;
        checks++; if (bus.class_code !== 2'd1 || bus.class_changed !== 1'b1) begin failures++; $display("FAIL red_confirmed got=%0d/%b exp=1/1", bus.class_code, bus.class_changed); end
        checks++; if (bus.match !== 1'b1) begin failures++; $display("FAIL red_match_sel001 got=%b exp=1", bus.match); end
        bus.sel = 3'b110; #1;
        checks++; if (bus.match !== 1'b0) begin failures++; $display("FAIL red_match_sel110 got=%b exp=0", bus.match); end
        bus.sel = 3'b001;
        @(posedge clk); #1;
        checks++; if (bus.class_changed !== 1'b0 || bus.class_code !== 2'd1) begin failures++; $display("FAIL red_chg_pulse got=%b/%0d exp=0/1", bus.class_changed, bus.class_code); end
        stop_scan();
    endtask

    task automatic test_tie();
        start_scan();
        run_frame(10, 10, 2, 0);
        #1;
        checks++; if (bus.frame_valid !== 1'b1 || bus.red_count !== 8'd10 || bus.green_count !== 8'd10 || bus.blue_count !== 8'd2) begin failures++; $display("FAIL tie_counts got=%b %0d/%0d/%0d exp=1 10/10/2", bus.frame_valid, bus.red_count, bus.green_count, bus.blue_count); end
        @(posedge clk); #1;
        checks++; if (bus.class_code !== 2'd1 || bus.class_changed !== 1'b0) begin failures++; $display("FAIL tie_hold got=%0d/%b exp=1/0", bus.class_code, bus.class_changed); end
        stop_scan();
    endtask

    task automatic test_en_drop();
        start_scan();
        run_channel(1'b0, 0, 7, 15, 2, 0);
        #1;
        checks++; if (bus.red_count !== 8'd7 || bus.green_count !== 8'd10) begin failures++; $display("FAIL drop_red_store got=%0d/%0d exp=7/10", bus.red_count, bus.green_count); end
        // green phase: settle, then drop en at count cycle 50
        repeat (15) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1 sensor = 1'b1; repeat (2) @(posedge clk);
            #1 sensor = 1'b0; repeat (2) @(posedge clk);
        end
        repeat (33) @(posedge clk);
        #1 bus.en = 1'b0;
        repeat (5) @(posedge clk); #1;
        checks++; if (bus.red_count !== 8'd7 || bus.green_count !== 8'd10 || bus.blue_count !== 8'd2) begin failures++; $display("FAIL drop_held got=%0d/%0d/%0d exp=7/10/2", bus.red_count, bus.green_count, bus.blue_count); end
        checks++; if ({bus.s2, bus.s3} !== 2'b00 || bus.frame_valid !== 1'b0) begin failures++; $display("FAIL drop_idle got=%b/%b exp=00/0", {bus.s2, bus.s3}, bus.frame_valid); end
        start_scan();
        run_channel(1'b0, 0, 9, 15, 2, 0);
        #1;
        checks++; if (bus.red_count !== 8'd9 || bus.green_count !== 8'd10) begin failures++; $display("FAIL drop_restart_red got=%0d/%0d exp=9/10", bus.red_count, bus.green_count); end
        run_channel(1'b0, 1, 3, 15, 2, 0);
        run_channel(1'b0, 2, 1, 15, 2, 0);
        #1;
        checks++; if (bus.frame_valid !== 1'b1 || bus.red_count !== 8'd9 || bus.green_count !== 8'd3 || bus.blue_count !== 8'd1) begin failures++; $display("FAIL drop_frame got=%b %0d/%0d/%0d exp=1 9/3/1", bus.frame_valid, bus.red_count, bus.green_count, bus.blue_count); end
        @(posedge clk); #1;
        checks++; if (bus.class_code !== 2'd1 || bus.class_changed !== 1'b0) begin failures++; $display("FAIL drop_class got=%0d/%b exp=1/0", bus.class_code, bus.class_changed); end
        stop_scan();
    endtask

    task automatic test_reset_mid_window();
        start_scan();
        run_channel(1'b0, 0, 5, 15, 2, 0);
        repeat (30) @(posedge clk);
        #1;
        checks++; if ({bus.s2, bus.s3} !== 2'b11 || bus.red_count !== 8'd5) begin failures++; $display("FAIL midrst_pre got=%b/%0d exp=11/5", {bus.s2, bus.s3}, bus.red_count); end
        #3 reset_n = 1'b0;
        #1;
        checks++; if ({bus.s2, bus.s3} !== 2'b00) begin failures++; $display("FAIL midrst_filter got=%b exp=00", {bus.s2, bus.s3}); end
        checks++; if (bus.red_count !== 8'd0 || bus.green_count !== 8'd0 || bus.blue_count !== 8'd0 || bus.clear_count !== 8'd0) begin failures++; $display("FAIL midrst_counts got=%0d/%0d/%0d/%0d exp=0/0/0/0", bus.red_count, bus.green_count, bus.blue_count, bus.clear_count); end
        checks++; if (bus.class_code !== 2'd0 || bus.class_changed !== 1'b0 || bus.frame_valid !== 1'b0 || bus.match !== 1'b0) begin failures++; $display("FAIL midrst_class got=%0d/%b/%b/%b exp=0/0/0/0", bus.class_code, bus.class_changed, bus.frame_valid, bus.match); end
        bus.en = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_settle_edges();
        start_scan();
        run_channel(1'b0, 0, 3, 1, 1, 0);
        run_channel(1'b0, 1, 3, 1, 1, 0);
        run_channel(1'b0, 2, 3, 1, 1, 0);
        #1;
        checks++; if (bus.frame_valid !== 1'b1 || bus.red_count !== 8'd0 || bus.green_count !== 8'd0 || bus.blue_count !== 8'd0) begin failures++; $display("FAIL settle_ignored got=%b %0d/%0d/%0d exp=1 0/0/0", bus.frame_valid, bus.red_count, bus.green_count, bus.blue_count); end
        stop_scan();
    endtask

    task automatic test_final_cycle_edge();
        start_scan();
        // rise at count cycle 98 -> synchronized edge in count cycle 99
        run_channel(1'b0, 0, 1, 108, 2, 0);
        #1;
        checks++; if (bus.red_count !== 8'd1) begin failures++; $display("FAIL last_cycle_edge got=%0d exp=1", bus.red_count); end
        run_channel(1'b0, 1, 0, 0, 2, 0);
        run_channel(1'b0, 2, 0, 0, 2, 0);
        #1;
        checks++; if (bus.frame_valid !== 1'b1 || bus.green_count !== 8'd0 || bus.blue_count !== 8'd0) begin failures++; $display("FAIL last_cycle_frame got=%b %0d/%0d exp=1 0/0", bus.frame_valid, bus.green_count, bus.blue_count); end
        stop_scan();
    endtask

    task automatic test_saturation();
        #1 sbus.en = 1'b1;
        @(posedge clk);
        run_channel(1'b1, 0, 300, 15, 1, 0);
        #1;
        checks++; if (sbus.red_count !== 8'd255) begin failures++; $display("FAIL sat_count got=%0d exp=255", sbus.red_count); end
        run_channel(1'b1, 1, 0, 0, 1, 0);
        run_channel(1'b1, 2, 0, 0, 1, 0);
        #1;
        checks++; if (sbus.frame_valid !== 1'b1 || sbus.red_count !== 8'd255 || sbus.green_count !== 8'd0) begin failures++; $display("FAIL sat_frame got=%b %0d/%0d exp=1 255/0", sbus.frame_valid, sbus.red_count, sbus.green_count); end
        #1 sbus.en = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        bus.en          = 1'b0;
        bus.scale       = 2'b10;
        bus.sel         = 3'b001;
        bus.min_thresh  = 8'd5;
        sbus.en         = 1'b0;
        sbus.scale      = 2'b10;
        sbus.sel        = 3'b001;
        sbus.min_thresh = 8'd5;

        test_reset();
        test_dominant_red();
        test_tie();
        test_en_drop();
        test_reset_mid_window();
        test_settle_edges();
        test_final_cycle_edge();
        test_saturation();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/color_scan_classifier.md
COLOR_SCAN_CLASSIFIER -- requirements
Module: color_scan_classifier

Interface
REQ-001 Parameter WINDOW_CYCLES, default 5_000_000; clk cycles per channel count window (50 ms at 100 MHz).
REQ-002 Parameter SETTLE_CYCLES, default 10_000; clk cycles per channel discarded after a filter change.
REQ-003 Parameter CNT_W, default 24; width of each channel count.
REQ-004 Parameter CONFIRM_N, default 3; consecutive identical frame classifications needed to update class_code.
REQ-005 clk input 1; system clock, all logic on rising edge.
REQ-006 reset_n input 1; asynchronous assert, active-low reset.
REQ-007 en input 1; 1 = scanning, 0 = idle.
REQ-008 scale input 2; drives {s0,s1} directly (TCS3200 output frequency scaling).
REQ-009 sensor_out input 1; TCS3200 OUT, asynchronous to clk.
REQ-010 sel input 3; target color select, bit0 red, bit1 green, bit2 blue.
REQ-011 min_thresh input CNT_W; minimum count for a dominant color.
REQ-012 s0, s1, s2, s3 output 1 each; TCS3200 control pins.
REQ-013 red_count, green_count, blue_count, clear_count output CNT_W each; last completed window results.
REQ-014 frame_valid output 1; one-cycle pulse when a full frame completes.
REQ-015 class_code output 2; debounced class, 0 none, 1 red, 2 green, 3 blue.
REQ-016 class_changed output 1; one-cycle pulse when class_code changes.
REQ-017 match output 1; 1 when class_code != 0 and sel has the bit for class_code set.

Function
REQ-018 sensor_out SHALL pass a 2-FF synchronizer; a rising edge is sync_q1 & ~sync_q2, one count per edge.
REQ-019 Filter codes {s2,s3}: red 00, green 11, blue 01, clear 10.
REQ-020 Channel order SHALL be red, green, blue, then clear (if compiled in), then back to red.
REQ-021 FSM states: IDLE, SETTLE, COUNT. IDLE->SETTLE on en=1. SETTLE->COUNT after SETTLE_CYCLES cycles. COUNT->SETTLE (next channel) after WINDOW_CYCLES cycles.
REQ-022 Edges arriving in IDLE or SETTLE SHALL be ignored.
REQ-023 {s2,s3} SHALL switch in the same cycle SETTLE is entered.
REQ-024 At the end of COUNT, the pulse count SHALL be written to that channel's output register, and the pulse count SHALL be cleared. An edge in the final COUNT cycle SHALL be counted.
REQ-025 The pulse count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 frame_valid SHALL pulse in the cycle after the last channel of the frame is stored.
REQ-027 Raw class is evaluated at frame_valid. A channel is dominant if it is strictly greater than the other two of R/G/B and greater than min_thresh. Ties or no qualifying channel give 0.
REQ-028 A confirm counter counts consecutive frames with the same raw class. When it reaches CONFIRM_N and the class differs from class_code, class_code SHALL update and class_changed SHALL pulse in that same cycle.
REQ-029 A different raw class SHALL restart the confirm counter at 1.
REQ-030 en deasserted mid-frame SHALL force IDLE next cycle, clear the pulse count and channel index, and hold the stored counts and class_code. Re-enable SHALL restart at red.
REQ-031 match SHALL be combinational from class_code and sel.

Reset
REQ-032 On reset_n=0: state IDLE, channel red, {s2,s3}=00, all counts 0, frame_valid 0, class_code 0, class_changed 0, confirm counter 0, synchronizer flops 0.
REQ-033 Reset asserted mid-window SHALL abort the window; no partial count is stored.

Configuration
REQ-034 Macro COLOR_CLEAR_CHANNEL_EN defined: 4-phase frame including clear (10), and clear_count is updated.
REQ-035 Macro COLOR_CLEAR_CHANNEL_EN undefined: 3-phase frame, clear_count constant 0, frame_valid after blue.

Verification (WINDOW_CYCLES=100, SETTLE_CYCLES=10, CONFIRM_N=2, CNT_W=8, min_thresh=5, macro undefined)
REQ-036 sensor_out toggled for 20 edges/window on red, 4 on green, 4 on blue, for 2 frames -> counts 20/4/4; class_code=1 and class_changed pulse at the 2nd frame_valid; sel=001 gives match=1.
REQ-037 Red and green both 10 edges, blue 2 -> raw class 0; class_code holds its previous value.
REQ-038 300 edges in one window with CNT_W=8 -> count = 255.
REQ-039 Edges injected only during SETTLE -> all counts 0.
REQ-040 en dropped at COUNT cycle 50 of green, then re-raised -> next stored channel is red; prior counts held.
REQ-041 reset_n pulsed low mid-window -> all outputs 0 and {s2,s3}=00 immediately, independent of clk.
